// File: rtl/fir_cap_pkg.sv
// fir_cap_pkg
//   Shared definitions for the FIR capture controller: default geometry,
//   the controller FSM state encoding and the FIR sample type.
//   No ports; imported by fir_cap_ram and fir_capture_ctrl.
package fir_cap_pkg;

    localparam int DEF_ADDR_W   = 9;
    localparam int DEF_DEPTH    = 512;
    localparam int DEF_OUT_W    = 35;
    localparam int DEF_PIPE_LAT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic signed [DEF_OUT_W-1:0] sample_t;

endpackage

// File: rtl/fir_cap_ram.sv
// fir_cap_ram
//   Simple dual-port capture buffer, DEPTH x OUT_W, one write port and one
//   registered read port. A read of the address being written in the same
//   cycle returns the previous contents. The array itself is never reset so
//   it maps onto block RAM; only the read register is cleared.
//
// Ports
//   clk      in   clock
//   rest     in   asynchronous active-high reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  read data, 1-cycle latency
module fir_cap_ram
    import fir_cap_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rest,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic signed [OUT_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic signed [OUT_W-1:0] rd_data
);

    logic signed [OUT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Separate block from the write so the read samples the pre-write word.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fir_capture_ctrl.sv
// fir_capture_ctrl
//   Sweeps the sample-ROM address 0..DEPTH-1 into the FIR datapath on each
//   start pulse, delays a valid flag by the ROM+FIR latency and captures the
//   DEPTH matching FIR outputs into an internal buffer (sample for address k
//   lands in buffer[k]). Results are read back through a registered port.
//
//   Optional build macro FIR_CAP_PEAK_EN adds the `peak` output: the largest
//   |fir_out| captured in the current sweep, most-negative saturated.
//
// Ports
//   clk      in   clock
//   rest     in   asynchronous active-high reset
//   start    in   one-cycle sweep request, honoured only in IDLE
//   address  out  ROM address to the FIR datapath
//   fir_out  in   FIR output sample (signed)
//   busy     out  high while sweeping or draining
//   done     out  one-cycle pulse after the last sample is written
//   rd_addr  in   capture buffer read address
//   rd_data  out  capture buffer word, 1-cycle latency
//   peak     out  (FIR_CAP_PEAK_EN only) max |fir_out| of the current sweep
module fir_capture_ctrl
    import fir_cap_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic                    clk,
    input  logic                    rest,
    input  logic                    start,
    output logic [ADDR_W-1:0]       address,
    input  logic signed [OUT_W-1:0] fir_out,
    output logic                    busy,
    output logic                    done,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic signed [OUT_W-1:0] rd_data
`ifdef FIR_CAP_PEAK_EN
    ,
    output logic [OUT_W-1:0]        peak
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic                push_p0;
    logic [PIPE_LAT-1:0] vld_p;
    logic                wr_en;
    logic                sweep_start;

    assign sweep_start = (state == IDLE) && start;
    assign push_p0     = (state == SWEEP);
    assign wr_en       = vld_p[PIPE_LAT-1];

    // Control FSM: address, busy and done are all registered here.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state   <= IDLE;
            address <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    address <= '0;
                    if (start) begin
                        state <= SWEEP;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    // Hold the terminal address instead of wrapping.
                    if (address == LAST_ADDR) begin
                        state <= DRAIN;
                    end else begin
                        address <= address + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (wr_en && (wr_ptr == LAST_ADDR)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        address <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stage p0 -> p1..pN: valid flag travels PIPE_LAT cycles alongside the
    // ROM+FIR pipeline so its tap lines up with the matching fir_out sample.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            vld_p  <= '0;
            wr_ptr <= '0;
        end else begin
            vld_p[0] <= push_p0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
            if (sweep_start) begin
                wr_ptr <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
        end
    end

    fir_cap_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .OUT_W  (OUT_W)
    ) u_ram (
        .clk     (clk),
        .rest    (rest),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (fir_out),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef FIR_CAP_PEAK_EN
    // Magnitude of a signed sample; the most-negative code has no positive
    // counterpart and clips to the largest positive value.
    function automatic logic [OUT_W-1:0] abs_sat(input logic signed [OUT_W-1:0] s);
        if (s[OUT_W-1] && (s[OUT_W-2:0] == '0)) begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end else if (s[OUT_W-1]) begin
            return $unsigned(-s);
        end else begin
            return $unsigned(s);
        end
    endfunction

    logic [OUT_W-1:0] mag;
    assign mag = abs_sat(fir_out);

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            peak <= '0;
        end else if (sweep_start) begin
            peak <= '0;
        end else if (wr_en && (mag > peak)) begin
            peak <= mag;
        end
    end
`endif

endmodule

// File: tb/tb_fir_capture_ctrl.sv
`timescale 1ns/1ps
module tb_fir_capture_ctrl;
    import fir_cap_pkg::*;

    localparam int ADDR_W    = 9;
    localparam int DEPTH     = 512;
    localparam int OUT_W     = 35;
    localparam int PIPE_LAT  = 3;
    // start seen in cycle t -> done in cycle t + SWEEP_CYC
    localparam int SWEEP_CYC = DEPTH + PIPE_LAT + 1;

    logic                    clk = 1'b0;
    logic                    rest = 1'b1;
    logic                    start = 1'b0;
    logic [ADDR_W-1:0]       address;
    logic signed [OUT_W-1:0] fir_out = '0;
    logic                    busy;
    logic                    done;
    logic [ADDR_W-1:0]       rd_addr = '0;
    logic signed [OUT_W-1:0] rd_data;
`ifdef FIR_CAP_PEAK_EN
    logic [OUT_W-1:0]        peak;
    logic [OUT_W-1:0]        obs_peak;
`endif

    always #5 clk = ~clk;

    fir_capture_ctrl #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .OUT_W    (OUT_W),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk     (clk),
        .rest    (rest),
        .start   (start),
        .address (address),
        .fir_out (fir_out),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
`ifdef FIR_CAP_PEAK_EN
        ,
        .peak    (peak)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM + FIR model: 3-cycle latency from address to fir_out.
    int     mode = 0;
    longint offs = 1000;

    function automatic logic signed [OUT_W-1:0] rom_fir(input int a);
        longint v;
        case (mode)
            0: v = longint'(a) + offs;
            1: begin
                case (a)
                    0:       v = -7;
                    1:       v = 42;
                    2:       v = -(longint'(1) <<< 34);
                    default: v = longint'(a);
                endcase
            end
            default: v = 0;
        endcase
        return OUT_W'(v);
    endfunction

    function automatic logic signed [OUT_W-1:0] exp_word(input int k, input longint o);
        return OUT_W'(longint'(k) + o);
    endfunction

    logic signed [OUT_W-1:0] fir_p1 = '0;
    logic signed [OUT_W-1:0] fir_p2 = '0;
    always @(posedge clk) begin
        fir_p1  <= rom_fir(int'(address));
        fir_p2  <= fir_p1;
        fir_out <= fir_p2;
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Observations collected during a sweep.
    int                      obs_done_cnt;
    int                      obs_done_at;
    int                      obs_busy_cnt;
    int                      obs_addr_err;
    logic                    obs_busy_rst;
    logic [ADDR_W-1:0]       obs_addr_rst;
    logic signed [OUT_W-1:0] obs_rd_old;
    logic signed [OUT_W-1:0] obs_rd_new;
    logic signed [OUT_W-1:0] snap [DEPTH];

    // Raises start in the current cycle and watches the sweep that follows.
    task automatic run_sweep(input int extra, input int rest_at, input int rd_k, input int tail);
        int t0;
        logic [ADDR_W-1:0] exp_a;
        obs_done_cnt = 0;
        obs_done_at  = -1;
        obs_busy_cnt = 0;
        obs_addr_err = 0;
        start = 1'b1;
        t0 = cyc;
        for (int i = 1; i <= SWEEP_CYC + tail; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (rest_at == i) begin
                rest = 1'b1;
                #1;
                obs_busy_rst = busy;
                obs_addr_rst = address;
                @(negedge clk);
                rest = 1'b0;
                break;
            end
            if (i - 1 < DEPTH) exp_a = ADDR_W'(i - 1);
            else if (i < SWEEP_CYC) exp_a = ADDR_W'(DEPTH - 1);
            else exp_a = '0;
            if (address !== exp_a) obs_addr_err++;
            if (busy === 1'b1) obs_busy_cnt++;
            if (done === 1'b1) begin
                obs_done_cnt++;
                if (obs_done_at < 0) obs_done_at = cyc - t0;
`ifdef FIR_CAP_PEAK_EN
                obs_peak = peak;
`endif
            end
            if (rd_k >= 0 && i == rd_k + 4) rd_addr = ADDR_W'(rd_k);
            if (rd_k >= 0 && i == rd_k + 5) obs_rd_old = rd_data;
            if (rd_k >= 0 && i == rd_k + 6) obs_rd_new = rd_data;
            if (extra != 0 && (i == 5 || i == 200 || i == SWEEP_CYC)) start = 1'b1;
        end
        start = 1'b0;
    endtask

    // Reads every buffer word back through the registered port.
    task automatic dump_buf();
        for (int k = 0; k <= DEPTH; k++) begin
            @(negedge clk);
            if (k > 0) snap[k-1] = rd_data;
            if (k < DEPTH) rd_addr = ADDR_W'(k);
        end
    endtask

    task automatic test_reset();
        rest = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_chk++; if (address !== '0) $display("FAIL reset_address: got %0d expected 0", address); else n_pass++;
        n_chk++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %0d expected 0", rd_data); else n_pass++;
`ifdef FIR_CAP_PEAK_EN
        n_chk++; if (peak !== '0) $display("FAIL reset_peak: got %0d expected 0", peak); else n_pass++;
`endif
        rest = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_sweep();
        int errs;
        int bad;
        mode = 0;
        offs = 1000;
        @(negedge clk);
        run_sweep(0, 0, -1, 2);
        n_chk++; if (obs_done_cnt !== 1) $display("FAIL sweep_done_count: got %0d expected 1", obs_done_cnt); else n_pass++;
        n_chk++; if (obs_done_at !== SWEEP_CYC) $display("FAIL sweep_done_latency: got %0d expected %0d", obs_done_at, SWEEP_CYC); else n_pass++;
        n_chk++; if (obs_busy_cnt !== SWEEP_CYC - 1) $display("FAIL sweep_busy_cycles: got %0d expected %0d", obs_busy_cnt, SWEEP_CYC - 1); else n_pass++;
        n_chk++; if (obs_addr_err !== 0) $display("FAIL sweep_address_seq: %0d wrong cycles, expected 0", obs_addr_err); else n_pass++;
        dump_buf();
        errs = 0;
        bad = 0;
        for (int k = DEPTH - 1; k >= 0; k--) if (snap[k] !== exp_word(k, 1000)) begin errs++; bad = k; end
        n_chk++;
        if (errs != 0) $display("FAIL sweep_buffer: %0d words wrong, word %0d got %0d expected %0d", errs, bad, snap[bad], exp_word(bad, 1000));
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int errs;
        int bad;
        offs = 3000;
        @(negedge clk);
        run_sweep(1, 0, -1, 4);
        n_chk++; if (obs_done_cnt !== 1) $display("FAIL ignore_done_count: got %0d expected 1", obs_done_cnt); else n_pass++;
        n_chk++; if (obs_done_at !== SWEEP_CYC) $display("FAIL ignore_done_latency: got %0d expected %0d", obs_done_at, SWEEP_CYC); else n_pass++;
        n_chk++; if (obs_busy_cnt !== SWEEP_CYC - 1) $display("FAIL ignore_busy_cycles: got %0d expected %0d", obs_busy_cnt, SWEEP_CYC - 1); else n_pass++;
        n_chk++; if (obs_addr_err !== 0) $display("FAIL ignore_address_seq: %0d wrong cycles, expected 0", obs_addr_err); else n_pass++;
        dump_buf();
        errs = 0;
        bad = 0;
        for (int k = DEPTH - 1; k >= 0; k--) if (snap[k] !== exp_word(k, 3000)) begin errs++; bad = k; end
        n_chk++;
        if (errs != 0) $display("FAIL ignore_buffer: %0d words wrong, word %0d got %0d expected %0d", errs, bad, snap[bad], exp_word(bad, 3000));
        else n_pass++;
    endtask

    task automatic test_rest_mid_sweep();
        int errs;
        int bad;
        logic signed [OUT_W-1:0] want;
        // Interrupted sweep uses a fresh offset so any late write is visible
        // against the 3000-offset words left by the previous sweep.
        offs = 5000;
        @(negedge clk);
        run_sweep(0, 101, -1, 0);
        n_chk++; if (obs_busy_rst !== 1'b0) $display("FAIL rest_busy: got %b expected 0", obs_busy_rst); else n_pass++;
        n_chk++; if (obs_addr_rst !== '0) $display("FAIL rest_address: got %0d expected 0", obs_addr_rst); else n_pass++;
        n_chk++; if (obs_addr_err !== 0 || obs_done_cnt !== 0) $display("FAIL rest_pre_sweep: addr errors %0d dones %0d, expected 0 and 0", obs_addr_err, obs_done_cnt); else n_pass++;
        repeat (8) @(negedge clk);
        dump_buf();
        errs = 0;
        bad = 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            want = (k <= 96) ? exp_word(k, 5000) : exp_word(k, 3000);
            if (snap[k] !== want) begin errs++; bad = k; end
        end
        n_chk++;
        if (errs != 0) $display("FAIL rest_buffer_kept: %0d words wrong, word %0d got %0d", errs, bad, snap[bad]);
        else n_pass++;
        offs = 1000;
        @(negedge clk);
        run_sweep(0, 0, -1, 1);
        n_chk++; if (obs_done_at !== SWEEP_CYC || obs_done_cnt !== 1) $display("FAIL rest_resweep_done: at %0d count %0d, expected %0d and 1", obs_done_at, obs_done_cnt, SWEEP_CYC); else n_pass++;
        dump_buf();
        errs = 0;
        bad = 0;
        for (int k = DEPTH - 1; k >= 0; k--) if (snap[k] !== exp_word(k, 1000)) begin errs++; bad = k; end
        n_chk++;
        if (errs != 0) $display("FAIL rest_resweep_buffer: %0d words wrong, word %0d got %0d expected %0d", errs, bad, snap[bad], exp_word(bad, 1000));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int first_at;
        int errs;
        int bad;
        offs = 2000;
        @(negedge clk);
        run_sweep(0, 0, -1, 0);
        first_at = obs_done_at;
        n_chk++; if (first_at !== SWEEP_CYC) $display("FAIL b2b_first_done: got %0d expected %0d", first_at, SWEEP_CYC); else n_pass++;
        offs = 4000;
        @(negedge clk);
        run_sweep(0, 0, -1, 1);
        n_chk++; if (obs_done_at !== SWEEP_CYC) $display("FAIL b2b_second_done: got %0d expected %0d", obs_done_at, SWEEP_CYC); else n_pass++;
        n_chk++; if (obs_addr_err !== 0) $display("FAIL b2b_address_seq: %0d wrong cycles, expected 0", obs_addr_err); else n_pass++;
        dump_buf();
        errs = 0;
        bad = 0;
        for (int k = DEPTH - 1; k >= 0; k--) if (snap[k] !== exp_word(k, 4000)) begin errs++; bad = k; end
        n_chk++;
        if (errs != 0) $display("FAIL b2b_buffer: %0d words wrong, word %0d got %0d expected %0d", errs, bad, snap[bad], exp_word(bad, 4000));
        else n_pass++;
    endtask

    task automatic test_read_during_capture();
        // Buffer holds the 4000-offset sweep; word 10 is rewritten with 6010.
        offs = 6000;
        @(negedge clk);
        run_sweep(0, 0, 10, 1);
        n_chk++; if (obs_rd_old !== exp_word(10, 4000)) $display("FAIL collide_old_data: got %0d expected %0d", obs_rd_old, exp_word(10, 4000)); else n_pass++;
        n_chk++; if (obs_rd_new !== exp_word(10, 6000)) $display("FAIL collide_new_data: got %0d expected %0d", obs_rd_new, exp_word(10, 6000)); else n_pass++;
    endtask

`ifdef FIR_CAP_PEAK_EN
    task automatic test_peak();
        mode = 1;
        @(negedge clk);
        run_sweep(0, 0, -1, 1);
        n_chk++; if (obs_done_cnt !== 1 || obs_peak !== 35'h3_FFFF_FFFF) $display("FAIL peak_saturated: got %0d expected %0d", obs_peak, 35'h3_FFFF_FFFF); else n_pass++;
        mode = 2;
        @(negedge clk);
        run_sweep(0, 0, -1, 1);
        n_chk++; if (obs_done_cnt !== 1 || obs_peak !== '0) $display("FAIL peak_zero_sweep: got %0d expected 0", obs_peak); else n_pass++;
        mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_full_sweep();
        test_start_ignored();
        test_rest_mid_sweep();
        test_back_to_back();
        test_read_during_capture();
`ifdef FIR_CAP_PEAK_EN
        test_peak();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
